aes_engine_scheduler: RTL and testbench

Shares one round-iterative AES engine (a forward cipher and an inverse cipher behind a common start/done interface) between an encrypt requester and a decrypt requester. Accepts 128-bit blocks over valid/ready handshakes and arbitrates round-robin on ties. Sequences the engine with a one-cycle start pulse, watches for completion with a watchdog, and returns the result to the owning requester over a valid/ready response channel. Sits between the system-side block interfaces and the cipher/inverse-cipher datapath.

---
 rtl/aes_engine_scheduler.sv | 165 ++++++++++++++++
 tb/tb_aes_engine_scheduler.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_engine_scheduler.sv
// Round-robin scheduler sharing one round-iterative AES engine between an
// encrypt requester and a decrypt requester, with a completion watchdog.
module aes_engine_scheduler #(
    parameter int Nk      = 4,
    parameter int Nr      = Nk + 6,
    parameter int TIMEOUT = Nr + 4
) (
    input  logic         clks,
    input  logic         reset,
    input  logic         enc_req_valid,
    input  logic         dec_req_valid,
    output logic         enc_req_ready,
    output logic         dec_req_ready,
    input  logic [0:127] enc_req_data,
    input  logic [0:127] dec_req_data,
    output logic         enc_rsp_valid,
    output logic         dec_rsp_valid,
    input  logic         enc_rsp_ready,
    input  logic         dec_rsp_ready,
    output logic [0:127] rsp_data,
    output logic         rsp_err,
    output logic         eng_start,
    output logic         eng_mode,
    output logic [0:127] eng_text,
    input  logic         eng_done,
    input  logic [0:127] eng_result,
    output logic         busy
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] WD_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   wd_cnt_r;
    logic            last_dec_r;
    logic            enc_rsp_valid_r;
    logic            dec_rsp_valid_r;
    logic [0:127]    rsp_data_r;
    logic            rsp_err_r;
    logic            eng_start_r;
    logic            eng_mode_r;
    logic [0:127]    eng_text_r;
    logic            busy_r;

    logic            grant_enc_s;
    logic            grant_dec_s;
    logic            req_fire_s;
    logic            rsp_take_s;
    logic            wd_expire_s;

    // Arbitration, request handshake and response acceptance
    always_comb begin
        // On a tie the requester that was not served last wins
        grant_dec_s = dec_req_valid & (~enc_req_valid | ~last_dec_r);
        grant_enc_s = enc_req_valid & ~grant_dec_s;
        if (reset && (state_r == IDLE)) begin
            enc_req_ready = grant_enc_s;
            dec_req_ready = grant_dec_s;
        end else begin
            enc_req_ready = 1'b0;
            dec_req_ready = 1'b0;
        end
        req_fire_s = enc_req_ready | dec_req_ready;
        if (eng_mode_r) begin
            rsp_take_s = dec_rsp_ready;
        end else begin
            rsp_take_s = enc_rsp_ready;
        end
        wd_expire_s = (wd_cnt_r == WD_LAST);
    end

    // Scheduler FSM with registered engine and response outputs
    always_ff @(posedge clks) begin
        if (!reset) begin
            state_r         <= IDLE;
            wd_cnt_r        <= '0;
            last_dec_r      <= 1'b1;
            enc_rsp_valid_r <= 1'b0;
            dec_rsp_valid_r <= 1'b0;
            rsp_data_r      <= 128'd0;
            rsp_err_r       <= 1'b0;
            eng_start_r     <= 1'b0;
            eng_mode_r      <= 1'b0;
            eng_text_r      <= 128'd0;
            busy_r          <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_fire_s) begin
                        eng_text_r  <= grant_dec_s ? dec_req_data : enc_req_data;
                        eng_mode_r  <= grant_dec_s;
                        eng_start_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    eng_start_r <= 1'b0;
                    wd_cnt_r    <= '0;
                    state_r     <= WAIT;
                end
                WAIT: begin
                    if (wd_cnt_r != WD_MAX) begin
                        wd_cnt_r <= wd_cnt_r + WD_ONE;
                    end
                    // A done arriving on the expiry cycle still delivers good data
                    if (eng_done) begin
                        rsp_data_r      <= eng_result;
                        rsp_err_r       <= 1'b0;
                        enc_rsp_valid_r <= ~eng_mode_r;
                        dec_rsp_valid_r <= eng_mode_r;
                        state_r         <= RESP;
                    end else if (wd_expire_s) begin
                        rsp_data_r      <= 128'd0;
                        rsp_err_r       <= 1'b1;
                        enc_rsp_valid_r <= ~eng_mode_r;
                        dec_rsp_valid_r <= eng_mode_r;
                        state_r         <= RESP;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                RESP: begin
                    if (rsp_take_s) begin
                        enc_rsp_valid_r <= 1'b0;
                        dec_rsp_valid_r <= 1'b0;
                        last_dec_r      <= eng_mode_r;
                        busy_r          <= 1'b0;
                        state_r         <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    enc_rsp_valid_r <= 1'b0;
                    dec_rsp_valid_r <= 1'b0;
                    eng_start_r     <= 1'b0;
                    busy_r          <= 1'b0;
                    state_r         <= IDLE;
                end
            endcase
        end
    end

    assign enc_rsp_valid = enc_rsp_valid_r;
    assign dec_rsp_valid = dec_rsp_valid_r;
    assign rsp_data      = rsp_data_r;
    assign rsp_err       = rsp_err_r;
    assign eng_start     = eng_start_r;
    assign eng_mode      = eng_mode_r;
    assign eng_text      = eng_text_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_aes_engine_scheduler.sv
// Scenario bench for aes_engine_scheduler with a behavioural engine model
// and a queue of expected responses.
module tb_aes_engine_scheduler;

    localparam int NK = 4;
    localparam int NR = NK + 6;
    localparam int TO = NR + 4;
    localparam logic [0:127] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clks;
    logic         reset;
    logic         enc_req_valid, dec_req_valid;
    logic         enc_req_ready, dec_req_ready;
    logic [0:127] enc_req_data, dec_req_data;
    logic         enc_rsp_valid, dec_rsp_valid;
    logic         enc_rsp_ready, dec_rsp_ready;
    logic [0:127] rsp_data;
    logic         rsp_err;
    logic         eng_start, eng_mode;
    logic [0:127] eng_text;
    logic         eng_done;
    logic [0:127] eng_result;
    logic         busy;

    typedef struct packed {
        logic         dec;
        logic [0:127] data;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic eng_never = 1'b1;
    int   eng_delay = 1;

    aes_engine_scheduler #(.Nk(NK)) dut (
        .clks(clks), .reset(reset),
        .enc_req_valid(enc_req_valid), .dec_req_valid(dec_req_valid),
        .enc_req_ready(enc_req_ready), .dec_req_ready(dec_req_ready),
        .enc_req_data(enc_req_data), .dec_req_data(dec_req_data),
        .enc_rsp_valid(enc_rsp_valid), .dec_rsp_valid(dec_rsp_valid),
        .enc_rsp_ready(enc_rsp_ready), .dec_rsp_ready(dec_rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_mode(eng_mode), .eng_text(eng_text),
        .eng_done(eng_done), .eng_result(eng_result), .busy(busy)
    );

    initial clks = 1'b0;
    always #5 clks = ~clks;

    // Stand-in cipher: the known FIPS-197 vector, otherwise a simple bijection per mode
    function automatic logic [0:127] model(input logic [0:127] t, input logic m);
        if (!m && t == PT) return CT;
        if (m && t == CT) return PT;
        if (!m) return {t[64:127], t[0:63]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        return t ^ 128'hdeadbeef0badf00dcafe1234a5a55a5a;
    endfunction

    function automatic logic [0:127] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Engine model: done pulse eng_delay cycles after the start pulse
    initial begin
        logic [0:127] txt;
        logic         md;
        eng_done = 1'b0;
        eng_result = 128'd0;
        forever begin
            @(posedge clks); #1;
            if (eng_start === 1'b1 && !eng_never) begin
                txt = eng_text;
                md  = eng_mode;
                repeat (eng_delay) @(posedge clks);
                #1;
                eng_done = 1'b1;
                eng_result = model(txt, md);
                @(posedge clks); #1;
                eng_done = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clks); #1;
        reset = 1'b0;
        repeat (2) @(posedge clks);
        #1 reset = 1'b1;
    endtask

    task automatic send(input logic dec, input logic [0:127] d, input logic [0:127] xd,
                        input logic xe, output bit ok);
        ok = 1'b0;
        @(posedge clks); #1;
        if (dec) begin dec_req_valid = 1'b1; dec_req_data = d; end
        else begin enc_req_valid = 1'b1; enc_req_data = d; end
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clks);
            if ((dec ? dec_req_ready : enc_req_ready) === 1'b1) begin
                sb.push_back('{dec, xd, xe});
                ok = 1'b1;
            end
        end
        @(posedge clks); #1;
        if (dec) dec_req_valid = 1'b0;
        else enc_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input logic dec, output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        while (!ok && cyc < 200) begin
            @(negedge clks);
            cyc++;
            if ((dec ? dec_rsp_valid : enc_rsp_valid) === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enc_req_valid = 1'b1; dec_req_valid = 1'b1;
        enc_req_data = PT; dec_req_data = CT;
        enc_rsp_ready = 1'b0; dec_rsp_ready = 1'b0;
        repeat (2) @(posedge clks);
        @(negedge clks);
        total++;
        if ({enc_req_ready, dec_req_ready, enc_rsp_valid, dec_rsp_valid,
             eng_start, busy, eng_mode, rsp_err} !== 8'd0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000000", {enc_req_ready, dec_req_ready,
                     enc_rsp_valid, dec_rsp_valid, eng_start, busy, eng_mode, rsp_err});
        end
        total++;
        if (rsp_data !== 128'd0 || eng_text !== 128'd0) begin
            bad++;
            $display("FAIL reset_data: rsp_data=%h eng_text=%h want 0", rsp_data, eng_text);
        end
        enc_req_valid = 1'b0; dec_req_valid = 1'b0;
        @(posedge clks); #1 reset = 1'b1;
        @(negedge clks);
        total++;
        if (busy !== 1'b0 || eng_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b eng_start=%b want 0 0", busy, eng_start);
        end
    endtask

    task automatic test_single_encrypt();
        bit ok, seen_dec;
        int cyc;
        exp_t e;
        eng_never = 1'b0; eng_delay = NR;
        enc_rsp_ready = 1'b1; dec_rsp_ready = 1'b1;
        send(1'b0, PT, CT, 1'b0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL enc_accept: got no enc_req_ready want 1"); end
        @(negedge clks);
        total++;
        if ({eng_start, eng_mode, busy} !== 3'b101 || eng_text !== PT) begin
            bad++;
            $display("FAIL enc_issue: start/mode/busy=%b text=%h want 101 %h",
                     {eng_start, eng_mode, busy}, eng_text, PT);
        end
        @(negedge clks);
        total++;
        if (eng_start !== 1'b0) begin bad++; $display("FAIL start_width: got %b want 0", eng_start); end
        seen_dec = 1'b0; ok = 1'b0; cyc = 0;
        while (!ok && cyc < 200) begin
            @(negedge clks);
            cyc++;
            if (dec_rsp_valid !== 1'b0) seen_dec = 1'b1;
            if (enc_rsp_valid === 1'b1) ok = 1'b1;
        end
        total++;
        if (!ok || cyc != NR) begin
            bad++;
            $display("FAIL enc_latency: got ok=%0d cyc=%0d want 1 %0d", ok, cyc, NR);
        end
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL enc_rsp: got empty scoreboard want entry"); end
        else begin
            e = sb.pop_front();
            if (rsp_data !== e.data || rsp_err !== e.err || dec_rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL enc_rsp: got %h err=%b want %h err=%b", rsp_data, rsp_err, e.data, e.err);
            end
        end
        total++;
        if (seen_dec) begin bad++; $display("FAIL enc_no_dec: got dec_rsp_valid=1 want 0"); end
        @(negedge clks);
        total++;
        if (enc_rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL enc_release: valid=%b busy=%b want 0 0", enc_rsp_valid, busy);
        end
    endtask

    task automatic test_simultaneous();
        logic [0:127] ed [2];
        logic [0:127] dd [2];
        int n_enc, n_dec, n_rsp, n_start;
        logic fire_e, fire_d, exp_m;
        exp_t e;
        do_reset();
        eng_never = 1'b0; eng_delay = 3;
        enc_rsp_ready = 1'b1; dec_rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin ed[i] = rnd128(); dd[i] = rnd128(); end
        n_enc = 0; n_dec = 0; n_rsp = 0; n_start = 0;
        enc_req_valid = 1'b1; enc_req_data = ed[0];
        dec_req_valid = 1'b1; dec_req_data = dd[0];
        for (int c = 0; c < 400 && n_rsp < 4; c++) begin
            @(negedge clks);
            if (eng_start === 1'b1) begin
                exp_m = (n_start % 2) != 0;
                total++;
                if (eng_mode !== exp_m) begin
                    bad++;
                    $display("FAIL rr_order: issue %0d mode=%b want %b", n_start, eng_mode, exp_m);
                end
                n_start++;
            end
            fire_e = enc_req_valid & enc_req_ready;
            fire_d = dec_req_valid & dec_req_ready;
            if (fire_e) sb.push_back('{1'b0, model(enc_req_data, 1'b0), 1'b0});
            if (fire_d) sb.push_back('{1'b1, model(dec_req_data, 1'b1), 1'b0});
            if (enc_rsp_valid === 1'b1 || dec_rsp_valid === 1'b1) begin
                n_rsp++;
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL rr_rsp: got empty scoreboard want entry"); end
                else begin
                    e = sb.pop_front();
                    if ({enc_rsp_valid, dec_rsp_valid} !== {~e.dec, e.dec} ||
                        rsp_data !== e.data || rsp_err !== e.err) begin
                        bad++;
                        $display("FAIL rr_rsp: got v=%b%b %h want v=%b%b %h", enc_rsp_valid,
                                 dec_rsp_valid, rsp_data, ~e.dec, e.dec, e.data);
                    end
                end
            end
            @(posedge clks); #1;
            if (fire_e) begin
                n_enc++;
                if (n_enc < 2) enc_req_data = ed[n_enc]; else enc_req_valid = 1'b0;
            end
            if (fire_d) begin
                n_dec++;
                if (n_dec < 2) dec_req_data = dd[n_dec]; else dec_req_valid = 1'b0;
            end
        end
        enc_req_valid = 1'b0; dec_req_valid = 1'b0;
        total++;
        if (n_rsp != 4 || n_start != 4) begin
            bad++;
            $display("FAIL rr_count: rsp=%0d start=%0d want 4 4", n_rsp, n_start);
        end
    endtask

    task automatic test_back_pressure();
        bit ok;
        int cyc;
        exp_t e;
        logic [0:127] d, dd;
        d = rnd128(); dd = rnd128();
        eng_never = 1'b0; eng_delay = 2;
        enc_rsp_ready = 1'b0; dec_rsp_ready = 1'b1;
        send(1'b0, d, model(d, 1'b0), 1'b0, ok);
        wait_rsp(1'b0, ok, cyc);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_rsp: got no enc_rsp_valid want 1"); end
        dec_req_valid = 1'b1; dec_req_data = dd;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (enc_rsp_valid !== 1'b1 || dec_rsp_valid !== 1'b0 || rsp_data !== model(d, 1'b0) ||
                rsp_err !== 1'b0 || enc_req_ready !== 1'b0 || dec_req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold: cycle %0d valid=%b%b data=%h ready=%b%b want 10 %h 00", i,
                         enc_rsp_valid, dec_rsp_valid, rsp_data, enc_req_ready, dec_req_ready, model(d, 1'b0));
            end
            @(negedge clks);
        end
        enc_rsp_ready = 1'b1;
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL bp_release: got empty scoreboard want entry"); end
        else begin
            e = sb.pop_front();
            if (enc_rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_err !== e.err) begin
                bad++;
                $display("FAIL bp_release: got v=%b %h want 1 %h", enc_rsp_valid, rsp_data, e.data);
            end
        end
        @(negedge clks);
        total++;
        if (busy !== 1'b0 || enc_rsp_valid !== 1'b0 || dec_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_idle: busy=%b valid=%b dec_ready=%b want 0 0 1", busy, enc_rsp_valid, dec_req_ready);
        end
        if (dec_req_ready === 1'b1) sb.push_back('{1'b1, model(dd, 1'b1), 1'b0});
        @(posedge clks); #1 dec_req_valid = 1'b0;
        wait_rsp(1'b1, ok, cyc);
        total++;
        if (!ok || sb.size() == 0) begin bad++; $display("FAIL bp_dec: got ok=%0d q=%0d want 1 1", ok, sb.size()); end
        else begin
            e = sb.pop_front();
            if (rsp_data !== e.data || rsp_err !== e.err) begin
                bad++;
                $display("FAIL bp_dec: got %h err=%b want %h 0", rsp_data, rsp_err, e.data);
            end
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        int cyc;
        exp_t e;
        eng_never = 1'b1;
        enc_rsp_ready = 1'b0; dec_rsp_ready = 1'b1;
        send(1'b0, rnd128(), 128'd0, 1'b1, ok);
        wait_rsp(1'b0, ok, cyc);
        total++;
        if (!ok || cyc != TO + 2) begin
            bad++;
            $display("FAIL wd_latency: got ok=%0d cyc=%0d want 1 %0d", ok, cyc, TO + 2);
        end
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL wd_rsp: got empty scoreboard want entry"); end
        else begin
            e = sb.pop_front();
            if (rsp_data !== e.data || rsp_err !== e.err) begin
                bad++;
                $display("FAIL wd_rsp: got %h err=%b want %h err=%b", rsp_data, rsp_err, e.data, e.err);
            end
        end
        @(posedge clks); #1 eng_done = 1'b1; eng_result = rnd128();
        @(posedge clks); #1 eng_done = 1'b0;
        @(negedge clks);
        total++;
        if (enc_rsp_valid !== 1'b1 || rsp_data !== 128'd0 || rsp_err !== 1'b1) begin
            bad++;
            $display("FAIL wd_late_resp: got v=%b %h err=%b want 1 0 1", enc_rsp_valid, rsp_data, rsp_err);
        end
        enc_rsp_ready = 1'b1;
        @(posedge clks); #1 eng_done = 1'b1;
        @(posedge clks); #1 eng_done = 1'b0;
        @(negedge clks);
        total++;
        if (busy !== 1'b0 || enc_rsp_valid !== 1'b0 || dec_rsp_valid !== 1'b0 || rsp_data !== 128'd0) begin
            bad++;
            $display("FAIL wd_late_idle: busy=%b v=%b%b data=%h want 0 00 0", busy,
                     enc_rsp_valid, dec_rsp_valid, rsp_data);
        end
    endtask

    task automatic test_done_on_timeout();
        bit ok;
        int cyc;
        exp_t e;
        logic [0:127] d;
        d = rnd128();
        eng_never = 1'b0; eng_delay = TO;
        enc_rsp_ready = 1'b1;
        send(1'b0, d, model(d, 1'b0), 1'b0, ok);
        wait_rsp(1'b0, ok, cyc);
        total++;
        if (!ok || cyc != TO + 2) begin
            bad++;
            $display("FAIL tie_latency: got ok=%0d cyc=%0d want 1 %0d", ok, cyc, TO + 2);
        end
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL tie_rsp: got empty scoreboard want entry"); end
        else begin
            e = sb.pop_front();
            if (rsp_data !== e.data || rsp_err !== e.err) begin
                bad++;
                $display("FAIL tie_rsp: got %h err=%b want %h err=%b", rsp_data, rsp_err, e.data, e.err);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok, seen;
        int cyc, gap;
        exp_t e;
        logic [0:127] de, dd;
        eng_never = 1'b1;
        send(1'b0, rnd128(), 128'd0, 1'b1, ok);
        repeat (3) @(negedge clks);
        @(posedge clks); #1 reset = 1'b0;
        @(posedge clks); #1 reset = 1'b1;
        sb.delete();
        @(negedge clks);
        total++;
        if ({enc_req_ready, dec_req_ready, enc_rsp_valid, dec_rsp_valid, eng_start, busy,
             eng_mode, rsp_err} !== 8'd0 || rsp_data !== 128'd0 || eng_text !== 128'd0) begin
            bad++;
            $display("FAIL mid_reset: ctrl=%b data=%h text=%h want 0", {enc_req_ready, dec_req_ready,
                     enc_rsp_valid, dec_rsp_valid, eng_start, busy, eng_mode, rsp_err}, rsp_data, eng_text);
        end
        @(posedge clks); #1 eng_done = 1'b1; eng_result = rnd128();
        @(posedge clks); #1 eng_done = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clks);
            if (enc_rsp_valid !== 1'b0 || dec_rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL mid_no_rsp: got response or busy after abort want none"); end
        eng_never = 1'b0; eng_delay = 1;
        enc_rsp_ready = 1'b1; dec_rsp_ready = 1'b1;
        de = rnd128(); dd = rnd128();
        @(posedge clks); #1;
        enc_req_valid = 1'b1; enc_req_data = de;
        dec_req_valid = 1'b1; dec_req_data = dd;
        @(negedge clks);
        total++;
        if (enc_req_ready !== 1'b1 || dec_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_tie: ready=%b%b want 10", enc_req_ready, dec_req_ready);
        end
        sb.push_back('{1'b0, model(de, 1'b0), 1'b0});
        @(posedge clks); #1 enc_req_valid = 1'b0;
        gap = 0; ok = 1'b0;
        while (!ok && gap < 20) begin
            @(negedge clks);
            gap++;
            if (enc_rsp_valid === 1'b1) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL b2b_enc: got empty scoreboard want entry"); end
                else begin
                    e = sb.pop_front();
                    if (rsp_data !== e.data || rsp_err !== e.err) begin
                        bad++;
                        $display("FAIL b2b_enc: got %h want %h", rsp_data, e.data);
                    end
                end
            end
            if (dec_req_ready === 1'b1) ok = 1'b1;
        end
        total++;
        if (!ok || gap != 4) begin bad++; $display("FAIL b2b_gap: got ok=%0d gap=%0d want 1 4", ok, gap); end
        sb.push_back('{1'b1, model(dd, 1'b1), 1'b0});
        @(posedge clks); #1 dec_req_valid = 1'b0;
        wait_rsp(1'b1, ok, cyc);
        total++;
        if (!ok || cyc != 3 || sb.size() != 1) begin
            bad++;
            $display("FAIL b2b_dec: got ok=%0d cyc=%0d q=%0d want 1 3 1", ok, cyc, sb.size());
        end else begin
            e = sb.pop_front();
            total++;
            if (rsp_data !== e.data || rsp_err !== e.err) begin
                bad++;
                $display("FAIL b2b_dec_data: got %h err=%b want %h 0", rsp_data, rsp_err, e.data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_encrypt();
        test_simultaneous();
        test_back_pressure();
        test_watchdog();
        test_done_on_timeout();
        test_reset_mid_wait();
        repeat (2) @(posedge clks);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
